bcd_serial_encoder: RTL and testbench

Sequential (double-dabble) binary-to-BCD converter with valid/ready handshakes on both sides. It produces the same result as the combinational `bcd_encoder` for the same `N`, but iterates one bit per clock through a single adjust-and-shift stage rather than unrolling the full add-3 array. It is meant for wide `N` or area-constrained paths, where N cycles of latency per conversion is acceptable.

---
 rtl/bcd_serial_encoder.sv | 110 +++++++++++
 tb/tb_bcd_serial_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_encoder.sv
// Iterative double-dabble binary to BCD converter.
// One adjust-and-shift step per clock, valid/ready on both sides.
module bcd_serial_encoder #(
  parameter  int N = 8,
  localparam int W = N + (N - 4) / 3 + 1
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] bcd
);

  localparam int ND = (W + 3) / 4;
  localparam int AW = 4 * ND;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  sreg_q;
  logic [N-1:0]  sreg_d;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] adj;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [W-1:0]  bcd_q;
  logic          in_ready_q;
  logic          out_valid_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;

  // One datapath step: add 3 to every digit above 4, then shift left.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < ND; i++) begin
      if (acc_q[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    {acc_d, sreg_d} = {adj, sreg_q} << 1;
    cnt_d = cnt_q + 1'b1;
  end

  // Control FSM; handshake outputs are registered with the state.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sreg_q     <= bin;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg_q <= sreg_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_d;
          if (cnt_q == LAST) begin
            bcd_q       <= acc_d[W-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Digits above W can never be set for an N-bit input.
  always @(posedge clk) begin
    if (aresetn && state_q == SHIFT && cnt_q == LAST) begin
      assert ((acc_d >> W) == '0);
    end
  end

endmodule

// File: tb/tb_bcd_serial_encoder.sv
// Self-checking bench for bcd_serial_encoder.
// Covers N=8 and N=16 instances.
module tb_bcd_serial_encoder;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;

  logic        vld8 = 1'b0;
  logic        rdy8;
  logic [7:0]  bin8 = '0;
  logic        ov8;
  logic        ordy8 = 1'b0;
  logic [9:0]  bcd8;

  logic        vld16 = 1'b0;
  logic        rdy16;
  logic [15:0] bin16 = '0;
  logic        ov16;
  logic        ordy16 = 1'b0;
  logic [20:0] bcd16;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  bcd_serial_encoder #(.N(8)) u8 (
    .clk      (clk),
    .aresetn  (aresetn),
    .in_valid (vld8),
    .in_ready (rdy8),
    .bin      (bin8),
    .out_valid(ov8),
    .out_ready(ordy8),
    .bcd      (bcd8)
  );

  bcd_serial_encoder #(.N(16)) u16 (
    .clk      (clk),
    .aresetn  (aresetn),
    .in_valid (vld16),
    .in_ready (rdy16),
    .bin      (bin16),
    .out_valid(ov16),
    .out_ready(ordy16),
    .bcd      (bcd16)
  );

  typedef struct {
    logic [7:0] b;
    logic [9:0] e;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [23:0] bcd_model(input int unsigned v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ov8(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov8 && n < 40);
  endtask

  task automatic run8(input logic [7:0] b,
                      input logic [9:0] e,
                      input string tag);
    int n;
    @(negedge clk);
    chk({tag, "_rdy_pre"}, 32'(rdy8), 1);
    vld8  = 1'b1;
    bin8  = b;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    vld8 = 1'b0;
    bin8 = ~b;
    chk({tag, "_rdy_busy"}, 32'(rdy8), 0);
    wait_ov8(n);
    chk({tag, "_lat"}, 32'(n), 8);
    chk({tag, "_bcd"}, 32'(bcd8), 32'(e));
    @(posedge clk); #1;
    chk({tag, "_rdy_idle"}, 32'(rdy8), 1);
    chk({tag, "_ov_idle"}, 32'(ov8), 0);
  endtask

  task automatic run16(input logic [15:0] b, input bit lat);
    int n;
    logic [23:0] m;
    m = bcd_model(32'(b));
    @(negedge clk);
    vld16  = 1'b1;
    bin16  = b;
    ordy16 = 1'b1;
    @(posedge clk); #1;
    vld16 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov16 && n < 60);
    if (lat) chk("n16_lat", 32'(n), 16);
    chk("n16_bcd", 32'(bcd16), 32'(m[20:0]));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int hits;
    logic [23:0] m;

    vecs[0] = '{8'd255, 10'h255};
    vecs[1] = '{8'd0,   10'h000};
    vecs[2] = '{8'd9,   10'h009};
    vecs[3] = '{8'd10,  10'h010};
    vecs[4] = '{8'd99,  10'h099};
    vecs[5] = '{8'd100, 10'h100};
    vecs[6] = '{8'd1,   10'h001};
    vecs[7] = '{8'd128, 10'h128};

    #12;
    chk("rst_rdy", 32'(rdy8), 1);
    chk("rst_ov", 32'(ov8), 0);
    chk("rst_bcd", 32'(bcd8), 0);
    @(negedge clk);
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Back-pressure with ignored inputs while busy.
    @(negedge clk);
    vld8  = 1'b1;
    bin8  = 8'd173;
    ordy8 = 1'b0;
    @(posedge clk); #1;
    bin8 = 8'd42;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      vld8 = ~vld8;
    end while (!ov8 && n < 40);
    chk("bp_lat", 32'(n), 8);
    vld8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ov", 32'(ov8), 1);
      chk("bp_bcd", 32'(bcd8), 32'h173);
      chk("bp_rdy", 32'(rdy8), 0);
    end
    @(negedge clk);
    ordy8 = 1'b1;
    @(posedge clk); #1;
    vld8 = 1'b0;
    chk("bp_rdy_idle", 32'(rdy8), 1);
    chk("bp_ov_idle", 32'(ov8), 0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) hits++;
    end
    chk("bp_no_accept", 32'(hits), 0);
    run8(8'd42, 10'h042, "bp_fresh");

    // Asynchronous reset during the 4th SHIFT cycle.
    @(negedge clk);
    vld8  = 1'b1;
    bin8  = 8'd200;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    vld8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("ar_rdy", 32'(rdy8), 1);
    chk("ar_ov", 32'(ov8), 0);
    chk("ar_bcd", 32'(bcd8), 0);
    @(negedge clk);
    aresetn = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) hits++;
    end
    chk("ar_no_ov", 32'(hits), 0);
    run8(8'd57, 10'h057, "ar_after");

    // Exhaustive N=8 with random gaps and back-pressure.
    for (int v = 0; v < 256; v++) begin
      m = bcd_model(32'(v));
      ordy8 = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      vld8 = 1'b1;
      bin8 = 8'(v);
      @(posedge clk); #1;
      vld8 = 1'b0;
      wait_ov8(n);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      if (!ov8 || bcd8 !== m[9:0]) begin
        chk($sformatf("ex%0d", v), {ov8, 21'b0, bcd8},
            {1'b1, 21'b0, m[9:0]});
      end else begin
        ncmp++;
      end
      @(negedge clk);
      ordy8 = 1'b1;
      @(posedge clk); #1;
    end
    ordy8 = 1'b0;

    // N=16 instance.
    run16(16'd65535, 1'b1);
    chk("n16_max", 32'(bcd16), 32'h065535);
    run16(16'd0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      run16(16'($urandom_range(0, 65535)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
